shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the execute stage. Replaces the
//  single-function combinational right shifter with a unit that does SLL, SRL,
//  SRA and ROR on XLEN-bit operands. It has a configurable number of register
//  slices, a valid/ready handshake, backpressure, a flush input and a pass-through
//  destination tag. It sits between the ALU operand muxes and the writeback select.
// PARAMETERS
//  XLEN      32  operand/result width; power of two, 8..64
//  NUM_REGS  2   pipeline registers inserted, 0..SHAMT_W (0 = combinational)
//  TAG_W     5   width of the tag carried alongside each op (rd index)
//  SHAMT_W   $clog2(XLEN)  localparam, shift-amount bits used
// PORTS
//  i_clk      in   1        clock, rising edge
//  i_rst_n    in   1        asynchronous reset, active low
//  i_valid    in   1        input op present
//  o_ready    out  1        unit accepts input this cycle
//  i_op       in   2        shift_pkg::shift_op_e: 00 SLL, 01 SRL, 10 SRA, 11 ROR
//  i_operand  in   XLEN     value to shift (rs1)
//  i_shamt    in   XLEN     shift amount (rs2/imm); only [SHAMT_W-1:0] used
//  i_tag      in   TAG_W    opaque tag, returned with the result
//  i_flush    in   1        synchronous kill of all in-flight ops
//  o_valid    out  1        result present
//  i_ready    in   1        consumer accepts result
//  o_result   out  XLEN     shifted value
//  o_tag      out  TAG_W    tag of the op in o_result
// BEHAVIOUR
//  - Reset (i_rst_n=0, async): all slice valid bits, o_valid, o_result and o_tag
//    go to 0. The data registers are also reset to 0.
//  - Datapath: SHAMT_W mux levels, LSB first (shift by 1, 2, 4, ...). Level k
//    applies 2^k when shamt bit k is 1.
//    SLL fills with 0. SRL fills with 0. SRA fills with operand[XLEN-1].
//    ROR wraps the LSBs into the MSBs.
//  - Sign bit, op and remaining shamt bits travel with each slice.
//  - Register r (1..NUM_REGS) sits after level floor(r*SHAMT_W/(NUM_REGS+1)).
//  - Latency: exactly NUM_REGS cycles from accept (i_valid&o_ready) to o_valid,
//    with no stall. With NUM_REGS=0, o_valid=i_valid, o_ready=i_ready and the
//    result is combinational.
//  - Handshake uses a global advance: adv = ~o_valid | i_ready; o_ready = adv.
//    All slices shift together when adv=1. Bubbles are not collapsed.
//  - While o_valid & ~i_ready: o_result and o_tag hold stable, and no slice changes.
//  - Ops leave in acceptance order. Throughput is 1 op/cycle when i_ready=1.
//  - i_flush=1: every valid bit is 0 after the edge, including an op offered in
//    the same cycle (it is dropped). o_ready may be 1 during flush.
//    Data registers need not clear.
//  - Shift amount 0 gives o_result = i_operand for all ops.
//  - Shamt bits above SHAMT_W-1 are ignored. For XLEN=32, shamt 0x24 shifts by 4.
//  - Reset asserted mid-operation discards all in-flight ops. There is no
//    partial output.
// STRUCTURE
//  - shift_pkg: typedef enum logic [1:0] shift_op_e {SHIFT_SLL, SHIFT_SRL,
//    SHIFT_SRA, SHIFT_ROR}.
//  - shift_pkg: function shamt_w(xlen).
//  - Sub-module shift_level #(XLEN, AMT): one combinational mux level for all
//    four ops. It is instantiated SHAMT_W times by generate. Slice registers live
//    in shift_pipe.
// TESTING (XLEN=32, NUM_REGS=2 unless noted)
//  1. SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF, o_valid 2 cycles after accept;
//     SRL same -> 0x0000_0001.
//  2. SRL 0xF000_0000 with i_shamt=0x0000_0024 -> 0x0F00_0000 (upper shamt bits ignored).
//  3. ROR 0x0000_0001 by 1 -> 0x8000_0000; SLL 0x1 by 31 -> 0x8000_0000;
//     any op by 0 -> operand.
//  4. Three back-to-back ops (tags 1, 2, 3) with i_ready=0 for 3 cycles ->
//     o_ready=0, o_result/o_tag held; released in order 1, 2, 3.
//  5. i_flush with 2 ops in flight plus 1 offered -> no o_valid for those ops;
//     next op is correct at latency 2.
//  6. Reset pulse mid-stream -> outputs 0 immediately. Also run a random sweep
//     vs a golden model for XLEN=64/NUM_REGS=0 and XLEN=32/NUM_REGS=5.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  function automatic int unsigned shamt_w(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

  // Index (1-based) of the pipeline register sitting at level boundary b, or 0 if none.
  function automatic int unsigned reg_at(input int unsigned b, input int unsigned nregs,
                                         input int unsigned shw);
    int unsigned found;
    found = 0;
    for (int unsigned r = 1; r <= nregs; r++) begin
      if ((r * shw) / (nregs + 1) == b) found = r;
    end
    return found;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One mux level of the barrel shifter: conditionally shifts/rotates right or left by AMT.
module shift_level
  import shift_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AMT  = 1
) (
  input  logic [XLEN-1:0] i_data,
  input  logic            i_sign,
  input  shift_op_e       i_op,
  input  logic            i_en,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_op)
        SHIFT_SLL: o_data = {i_data[XLEN-AMT-1:0], {AMT{1'b0}}};
        SHIFT_SRL: o_data = {{AMT{1'b0}}, i_data[XLEN-1:AMT]};
        SHIFT_SRA: o_data = {{AMT{i_sign}}, i_data[XLEN-1:AMT]};
        SHIFT_ROR: o_data = {i_data[AMT-1:0], i_data[XLEN-1:AMT]};
        default:   o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with global-advance valid/ready,
// flush and a pass-through destination tag.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 2,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  shift_op_e        i_op,
  input  logic [XLEN-1:0]  i_operand,
  input  logic [XLEN-1:0]  i_shamt,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned SHAMT_W = shamt_w(XLEN);

  logic               adv;
  logic [XLEN-1:0]    at_data [SHAMT_W];
  logic               at_sign [SHAMT_W];
  shift_op_e          at_op   [SHAMT_W];
  logic [SHAMT_W-1:0] at_amt  [SHAMT_W];
  logic [XLEN-1:0]    lvl_out [SHAMT_W];

  logic unused_shamt;
  assign unused_shamt = ^i_shamt[XLEN-1:SHAMT_W];

  // Payload entering each level; a slice register is placed at some boundaries.
  for (genvar b = 0; b < SHAMT_W; b++) begin : g_bnd
    localparam int unsigned R = reg_at(b, NUM_REGS, SHAMT_W);
    logic [XLEN-1:0]    src_data;
    logic               src_sign;
    shift_op_e          src_op;
    logic [SHAMT_W-1:0] src_amt;

    if (b == 0) begin : g_src_in
      assign src_data = i_operand;
      assign src_sign = i_operand[XLEN-1];
      assign src_op   = i_op;
      assign src_amt  = i_shamt[SHAMT_W-1:0];
    end else begin : g_src_lvl
      assign src_data = lvl_out[b-1];
      assign src_sign = at_sign[b-1];
      assign src_op   = at_op[b-1];
      assign src_amt  = at_amt[b-1];
    end

    if (R != 0) begin : g_reg
      logic [XLEN-1:0]    data_d, data_q;
      logic               sign_d, sign_q;
      shift_op_e          op_d,   op_q;
      logic [SHAMT_W-1:0] amt_d,  amt_q;

      always_comb begin
        data_d = data_q;
        sign_d = sign_q;
        op_d   = op_q;
        amt_d  = amt_q;
        if (adv) begin
          data_d = src_data;
          sign_d = src_sign;
          op_d   = src_op;
          amt_d  = src_amt;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          data_q <= '0;
          sign_q <= 1'b0;
          op_q   <= SHIFT_SLL;
          amt_q  <= '0;
        end else begin
          data_q <= data_d;
          sign_q <= sign_d;
          op_q   <= op_d;
          amt_q  <= amt_d;
        end
      end

      assign at_data[b] = data_q;
      assign at_sign[b] = sign_q;
      assign at_op[b]   = op_q;
      assign at_amt[b]  = amt_q;
    end else begin : g_thru
      assign at_data[b] = src_data;
      assign at_sign[b] = src_sign;
      assign at_op[b]   = src_op;
      assign at_amt[b]  = src_amt;
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    shift_level #(
      .XLEN(XLEN),
      .AMT (1 << k)
    ) u_level (
      .i_data(at_data[k]),
      .i_sign(at_sign[k]),
      .i_op  (at_op[k]),
      .i_en  (at_amt[k][k]),
      .o_data(lvl_out[k])
    );
  end

  assign o_result = lvl_out[SHAMT_W-1];

  if (NUM_REGS == 0) begin : g_comb
    logic unused_ctrl;
    assign adv         = i_ready;
    assign o_ready     = i_ready;
    assign o_valid     = i_valid;
    assign o_tag       = i_tag;
    assign unused_ctrl = i_flush | adv;
  end else begin : g_pipe
    logic [NUM_REGS-1:0] vld_d, vld_q;
    logic [TAG_W-1:0]    tag_d [NUM_REGS];
    logic [TAG_W-1:0]    tag_q [NUM_REGS];

    // Valid and tag chain; all slices move together, bubbles are kept.
    always_comb begin
      vld_d = vld_q;
      tag_d = tag_q;
      if (adv) begin
        vld_d[0] = i_valid;
        tag_d[0] = i_tag;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
          vld_d[r] = vld_q[r-1];
          tag_d[r] = tag_q[r-1];
        end
      end
      if (i_flush) vld_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        vld_q <= '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) tag_q[r] <= '0;
      end else begin
        vld_q <= vld_d;
        tag_q <= tag_d;
      end
    end

    assign o_valid = vld_q[NUM_REGS-1];
    assign o_tag   = tag_q[NUM_REGS-1];
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed cases on XLEN=32/NUM_REGS=2 plus
// random sweeps on XLEN=64/NUM_REGS=0 and XLEN=32/NUM_REGS=5.
module tb_shift_pipe;
  import shift_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // DUT A: XLEN=32, NUM_REGS=2
  logic a_vi, a_ro, a_fl, a_vo, a_ri;
  shift_op_e a_op;
  logic [31:0] a_x, a_sh, a_res;
  logic [4:0]  a_ti, a_to;
  // DUT B: XLEN=64, NUM_REGS=0
  logic b_vi, b_ro, b_fl, b_vo, b_ri;
  shift_op_e b_op;
  logic [63:0] b_x, b_sh, b_res;
  logic [4:0]  b_ti, b_to;
  // DUT C: XLEN=32, NUM_REGS=5
  logic c_vi, c_ro, c_fl, c_vo, c_ri;
  shift_op_e c_op;
  logic [31:0] c_x, c_sh, c_res;
  logic [4:0]  c_ti, c_to;

  shift_pipe #(.XLEN(32), .NUM_REGS(2), .TAG_W(5)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_vi), .o_ready(a_ro), .i_op(a_op),
    .i_operand(a_x), .i_shamt(a_sh), .i_tag(a_ti), .i_flush(a_fl), .o_valid(a_vo),
    .i_ready(a_ri), .o_result(a_res), .o_tag(a_to));

  shift_pipe #(.XLEN(64), .NUM_REGS(0), .TAG_W(5)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_vi), .o_ready(b_ro), .i_op(b_op),
    .i_operand(b_x), .i_shamt(b_sh), .i_tag(b_ti), .i_flush(b_fl), .o_valid(b_vo),
    .i_ready(b_ri), .o_result(b_res), .o_tag(b_to));

  shift_pipe #(.XLEN(32), .NUM_REGS(5), .TAG_W(5)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_vi), .o_ready(c_ro), .i_op(c_op),
    .i_operand(c_x), .i_shamt(c_sh), .i_tag(c_ti), .i_flush(c_fl), .o_valid(c_vo),
    .i_ready(c_ri), .o_result(c_res), .o_tag(c_to));

  // Arithmetic reference model, independent of the mux-level structure.
  function automatic logic [63:0] golden(input shift_op_e op, input logic [63:0] x_in,
                                         input logic [63:0] sh, input int xl);
    logic [63:0] mask, x, r;
    int amt;
    mask = (xl == 64) ? '1 : ((64'd1 << xl) - 64'd1);
    x    = x_in & mask;
    amt  = int'(sh[5:0]) & (xl - 1);
    case (op)
      SHIFT_SLL: r = (x << amt) & mask;
      SHIFT_SRL: r = x >> amt;
      SHIFT_SRA: begin
        r = x >> amt;
        if (x[xl-1]) r = r | (mask & ~(mask >> amt));
      end
      default:   r = ((x >> amt) | (x << (xl - amt))) & mask;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b expected 0", a_vo); end
    n_checks++; if (a_res !== 32'h0) begin n_fail++; $display("FAIL reset_o_result: got %h expected 0", a_res); end
    n_checks++; if (a_to !== 5'h0) begin n_fail++; $display("FAIL reset_o_tag: got %h expected 0", a_to); end
    n_checks++; if (c_vo !== 1'b0 || c_res !== 32'h0) begin n_fail++; $display("FAIL reset_c_out: got %b/%h expected 0/0", c_vo, c_res); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (a_ro !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %b expected 1", a_ro); end
    n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL idle_o_valid: got %b expected 0", a_vo); end
  endtask

  task automatic test_directed();
    shift_op_e   ops [10];
    logic [31:0] xs  [10];
    logic [31:0] shs [10];
    logic [31:0] exps[10];
    exp_t e;
    int sent = 0, got = 0, guard = 0;
    ops[0] = SHIFT_SRA; xs[0] = 32'h8000_0000; shs[0] = 32'd31;         exps[0] = 32'hFFFF_FFFF;
    ops[1] = SHIFT_SRL; xs[1] = 32'h8000_0000; shs[1] = 32'd31;         exps[1] = 32'h0000_0001;
    ops[2] = SHIFT_SRL; xs[2] = 32'hF000_0000; shs[2] = 32'h0000_0024; exps[2] = 32'h0F00_0000;
    ops[3] = SHIFT_ROR; xs[3] = 32'h0000_0001; shs[3] = 32'd1;          exps[3] = 32'h8000_0000;
    ops[4] = SHIFT_SLL; xs[4] = 32'h0000_0001; shs[4] = 32'd31;         exps[4] = 32'h8000_0000;
    ops[5] = SHIFT_SLL; xs[5] = 32'hA5C3_1E0F; shs[5] = 32'd0;          exps[5] = 32'hA5C3_1E0F;
    ops[6] = SHIFT_SRL; xs[6] = 32'hA5C3_1E0F; shs[6] = 32'd0;          exps[6] = 32'hA5C3_1E0F;
    ops[7] = SHIFT_SRA; xs[7] = 32'hA5C3_1E0F; shs[7] = 32'd0;          exps[7] = 32'hA5C3_1E0F;
    ops[8] = SHIFT_ROR; xs[8] = 32'hA5C3_1E0F; shs[8] = 32'd0;          exps[8] = 32'hA5C3_1E0F;
    ops[9] = SHIFT_SRA; xs[9] = 32'h8000_0000; shs[9] = 32'h0000_0020; exps[9] = 32'h8000_0000;
    a_ri = 1'b1;
    while (got < 10 && guard < 100) begin
      a_vi = (sent < 10);
      if (sent < 10) begin
        a_op = ops[sent]; a_x = xs[sent]; a_sh = shs[sent]; a_ti = 5'(sent + 1);
      end
      #3;
      if (a_vo && a_ri) begin
        if (qa.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL directed_spurious: got tag %0d expected no output", a_to);
        end else begin
          e = qa.pop_front();
          n_checks++;
          if (a_res !== e.res[31:0] || a_to !== e.tag) begin
            n_fail++; $display("FAIL directed_result: got %h tag %0d expected %h tag %0d", a_res, a_to, e.res[31:0], e.tag);
          end
          n_checks++;
          if (cyc - e.cyc != 2) begin
            n_fail++; $display("FAIL directed_latency tag %0d: got %0d expected 2", e.tag, cyc - e.cyc);
          end
        end
        got++;
      end
      if (a_vi && a_ro) begin
        e.res = {32'h0, exps[sent]}; e.tag = 5'(sent + 1); e.cyc = cyc;
        qa.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      guard++;
    end
    a_vi = 1'b0;
    n_checks++; if (got != 10) begin n_fail++; $display("FAIL directed_timeout: got %0d results expected 10", got); end
  endtask

  task automatic test_back_to_back();
    shift_op_e   ops [3];
    logic [31:0] xs  [3];
    logic [31:0] shs [3];
    logic [31:0] exps[3];
    exp_t e;
    int sent = 0, got = 0, stall = 0, guard = 0;
    ops[0] = SHIFT_SLL; xs[0] = 32'h1234_5678; shs[0] = 32'd4;  exps[0] = 32'h2345_6780;
    ops[1] = SHIFT_SRA; xs[1] = 32'h8765_4321; shs[1] = 32'd8;  exps[1] = 32'hFF87_6543;
    ops[2] = SHIFT_ROR; xs[2] = 32'hDEAD_BEEF; shs[2] = 32'd16; exps[2] = 32'hBEEF_DEAD;
    while (got < 3 && guard < 60) begin
      a_vi = (sent < 3);
      if (sent < 3) begin
        a_op = ops[sent]; a_x = xs[sent]; a_sh = shs[sent]; a_ti = 5'(sent + 1);
      end
      a_ri = (stall >= 3);
      #3;
      if (a_vo && !a_ri) begin
        stall++;
        n_checks++; if (a_ro !== 1'b0) begin n_fail++; $display("FAIL stall_o_ready: got %b expected 0", a_ro); end
        n_checks++;
        if (qa.size() == 0 || a_res !== qa[0].res[31:0] || a_to !== qa[0].tag) begin
          n_fail++; $display("FAIL stall_hold: got %h tag %0d expected tag 1 result %h", a_res, a_to, exps[0]);
        end
      end
      if (a_vo && a_ri) begin
        n_checks++; if (a_to !== 5'(got + 1)) begin n_fail++; $display("FAIL b2b_order: got tag %0d expected %0d", a_to, got + 1); end
        if (qa.size() != 0) begin
          e = qa.pop_front();
          n_checks++;
          if (a_res !== e.res[31:0]) begin n_fail++; $display("FAIL b2b_result: got %h expected %h", a_res, e.res[31:0]); end
        end
        got++;
      end
      if (a_vi && a_ro) begin
        e.res = {32'h0, exps[sent]}; e.tag = 5'(sent + 1); e.cyc = cyc;
        qa.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      guard++;
    end
    a_vi = 1'b0; a_ri = 1'b1;
    n_checks++; if (got != 3 || stall != 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d results %0d stalls expected 3 and 3", got, stall); end
  endtask

  task automatic test_flush();
    exp_t e;
    a_ri = 1'b1; a_vi = 1'b1; a_op = SHIFT_SLL; a_x = 32'h1; a_sh = 32'd1; a_ti = 5'd10;
    @(posedge clk); #1;
    a_ti = 5'd11; a_x = 32'h2;
    @(posedge clk); #1;
    a_ri = 1'b0; a_ti = 5'd12; a_x = 32'h3; a_fl = 1'b1;
    #3;
    n_checks++; if (a_vo !== 1'b1 || a_to !== 5'd10) begin n_fail++; $display("FAIL flush_pre: got valid %b tag %0d expected 1 tag 10", a_vo, a_to); end
    @(posedge clk); #1;
    a_fl = 1'b0; a_vi = 1'b0; a_ri = 1'b1;
    repeat (4) begin
      #3;
      n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL flush_killed: got valid %b tag %0d expected 0", a_vo, a_to); end
      @(posedge clk); #1;
    end
    // Flush arriving while one op is in flight and another is offered.
    a_vi = 1'b1; a_ti = 5'd13;
    @(posedge clk); #1;
    a_ti = 5'd14; a_fl = 1'b1;
    #3;
    n_checks++; if (a_ro !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", a_ro); end
    @(posedge clk); #1;
    a_fl = 1'b0; a_vi = 1'b0;
    repeat (4) begin
      #3;
      n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL flush_offered: got valid %b tag %0d expected 0", a_vo, a_to); end
      @(posedge clk); #1;
    end
    a_vi = 1'b1; a_op = SHIFT_SRA; a_x = 32'hF000_000F; a_sh = 32'd4; a_ti = 5'd15;
    #3;
    if (a_ro) begin e.res = 64'hFF00_0000; e.tag = 5'd15; e.cyc = cyc; qa.push_back(e); end
    @(posedge clk); #1;
    a_vi = 1'b0;
    #3;
    n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL post_flush_early: got valid %b expected 0", a_vo); end
    @(posedge clk); #1; #3;
    n_checks++;
    if (!a_vo || qa.size() == 0) begin
      n_fail++; $display("FAIL post_flush_latency: got valid %b queue %0d expected valid 1", a_vo, qa.size());
    end else begin
      e = qa.pop_front();
      if (a_res !== e.res[31:0] || a_to !== e.tag) begin
        n_fail++; $display("FAIL post_flush_result: got %h tag %0d expected %h tag %0d", a_res, a_to, e.res[31:0], e.tag);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    a_ri = 1'b0; a_vi = 1'b1; a_op = SHIFT_SLL; a_x = 32'h3; a_sh = 32'd1; a_ti = 5'd20;
    @(posedge clk); #1;
    a_ti = 5'd21;
    @(posedge clk); #1;
    a_vi = 1'b0;
    #1;
    n_checks++; if (a_vo !== 1'b1 || a_res !== 32'h6) begin n_fail++; $display("FAIL rstmid_pre: got valid %b result %h expected 1 and 6", a_vo, a_res); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL rstmid_o_valid: got %b expected 0", a_vo); end
    n_checks++; if (a_res !== 32'h0) begin n_fail++; $display("FAIL rstmid_o_result: got %h expected 0", a_res); end
    n_checks++; if (a_to !== 5'h0) begin n_fail++; $display("FAIL rstmid_o_tag: got %h expected 0", a_to); end
    #1;
    rst_n = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    a_ri = 1'b1;
    repeat (3) begin
      #3;
      n_checks++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL rstmid_partial: got valid %b tag %0d expected 0", a_vo, a_to); end
      @(posedge clk); #1;
    end
    a_vi = 1'b1; a_op = SHIFT_SLL; a_x = 32'h0000_00FF; a_sh = 32'd8; a_ti = 5'd22;
    #3;
    if (a_ro) begin e.res = 64'h0000_FF00; e.tag = 5'd22; e.cyc = cyc; qa.push_back(e); end
    @(posedge clk); #1;
    a_vi = 1'b0;
    @(posedge clk); #1; #3;
    n_checks++;
    if (!a_vo || qa.size() == 0) begin
      n_fail++; $display("FAIL rstmid_resume: got valid %b queue %0d expected valid 1", a_vo, qa.size());
    end else begin
      e = qa.pop_front();
      if (a_res !== e.res[31:0] || a_to !== e.tag) begin
        n_fail++; $display("FAIL rstmid_resume_result: got %h tag %0d expected %h tag %0d", a_res, a_to, e.res[31:0], e.tag);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_comb();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      b_vi = 1'($urandom_range(0, 1));
      b_ri = 1'($urandom_range(0, 1));
      b_op = shift_op_e'(2'($urandom_range(0, 3)));
      b_x  = {$urandom, $urandom};
      b_sh = {$urandom, $urandom};
      b_ti = 5'($urandom);
      #3;
      n_checks++; if (b_ro !== b_ri || b_vo !== b_vi) begin n_fail++; $display("FAIL comb_handshake: got ready %b valid %b expected %b %b", b_ro, b_vo, b_ri, b_vi); end
      if (b_vi && b_ro) begin
        e.res = golden(b_op, b_x, b_sh, 64); e.tag = b_ti; e.cyc = cyc;
        qb.push_back(e);
      end
      if (b_vo && b_ri && qb.size() != 0) begin
        e = qb.pop_front();
        n_checks++;
        if (b_res !== e.res || b_to !== e.tag) begin
          n_fail++; $display("FAIL comb_result op %0d x %h sh %h: got %h tag %0d expected %h tag %0d", b_op, b_x, b_sh, b_res, b_to, e.res, e.tag);
        end
      end
      @(posedge clk); #1;
    end
    b_vi = 1'b0;
    n_checks++; if (qb.size() != 0) begin n_fail++; $display("FAIL comb_leftover: got %0d expected 0", qb.size()); end
  endtask

  task automatic test_random_deep();
    exp_t e;
    int guard = 0;
    for (int i = 0; i < 400; i++) begin
      c_vi = ($urandom_range(0, 3) != 0);
      c_ri = ($urandom_range(0, 9) < 7);
      c_op = shift_op_e'(2'($urandom_range(0, 3)));
      c_x  = ($urandom_range(0, 1) != 0) ? $urandom : {1'b1, 31'($urandom)};
      c_sh = $urandom;
      c_ti = 5'($urandom);
      #3;
      if (c_vo && !c_ri) begin
        n_checks++; if (c_ro !== 1'b0) begin n_fail++; $display("FAIL deep_backpressure: got ready %b expected 0", c_ro); end
      end
      if (c_vo && c_ri) begin
        if (qc.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL deep_spurious: got tag %0d expected no output", c_to);
        end else begin
          e = qc.pop_front();
          n_checks++;
          if (c_res !== e.res[31:0] || c_to !== e.tag) begin
            n_fail++; $display("FAIL deep_result: got %h tag %0d expected %h tag %0d", c_res, c_to, e.res[31:0], e.tag);
          end
        end
      end
      if (c_vi && c_ro) begin
        e.res = golden(c_op, {32'h0, c_x}, {32'h0, c_sh}, 32); e.tag = c_ti; e.cyc = cyc;
        qc.push_back(e);
      end
      @(posedge clk); #1;
    end
    c_vi = 1'b0; c_ri = 1'b1;
    while (qc.size() != 0 && guard < 50) begin
      #3;
      if (c_vo) begin
        e = qc.pop_front();
        n_checks++;
        if (c_res !== e.res[31:0] || c_to !== e.tag) begin
          n_fail++; $display("FAIL deep_drain: got %h tag %0d expected %h tag %0d", c_res, c_to, e.res[31:0], e.tag);
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    n_checks++; if (qc.size() != 0) begin n_fail++; $display("FAIL deep_timeout: got %0d pending expected 0", qc.size()); end
  endtask

  initial begin
    a_vi = 1'b0; a_ri = 1'b1; a_fl = 1'b0; a_op = SHIFT_SLL; a_x = '0; a_sh = '0; a_ti = '0;
    b_vi = 1'b0; b_ri = 1'b1; b_fl = 1'b0; b_op = SHIFT_SLL; b_x = '0; b_sh = '0; b_ti = '0;
    c_vi = 1'b0; c_ri = 1'b1; c_fl = 1'b0; c_op = SHIFT_SLL; c_x = '0; c_sh = '0; c_ti = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random_comb();
    test_random_deep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
